ks_adder_pipe: RTL and testbench

//  Parametrised, pipelined Kogge-Stone prefix adder with valid/ready handshake and sideband tag.

---
 rtl/ks_pkg.sv | 23 ++
 rtl/ks_prefix_level.sv | 21 ++
 rtl/ks_adder_pipe.sv | 140 ++++++++++++++
 tb/tb_ks_adder_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared Kogge-Stone prefix types and helpers: (p,g) pair, prefix combine cell, pipeline stage count.
package ks_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Black cell; acts as a gray cell when lo.p=0, which is the case for the carry-in position.
  function automatic pg_t ks_combine(pg_t hi, pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int KS_NPFX(int width, int lps);
    int log2w;
    log2w = $clog2(width);
    return (log2w + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level at distance DIST.
// Position 0 is bit -1 (carry-in); position j holds bit j-1.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  pg_t [WIDTH:0] pg_in,
  output pg_t [WIDTH:0] pg_out
);

  for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
    if (j >= DIST) begin : g_cell
      assign pg_out[j] = ks_combine(pg_in[j], pg_in[j-DIST]);
    end else begin : g_pass
      assign pg_out[j] = pg_in[j];
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready and sideband tag; latency NPFX+2, global stall on out_ready.
// Optional subtract mode and signed-overflow output under KS_ADDER_SUB_EN.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LVL_PER_STG = 1,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
`ifdef KS_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef KS_ADDER_SUB_EN
  output logic             out_ovf,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int NPFX  = KS_NPFX(WIDTH, LVL_PER_STG);

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  pg_t  [WIDTH:0]   pg0;

  pg_t  [WIDTH:0]   stg_pg  [0:NPFX];
  logic [WIDTH-1:0] stg_p   [0:NPFX];
  logic [TAG_W-1:0] stg_tag [0:NPFX];
  logic             stg_vld [0:NPFX];
  pg_t  [WIDTH:0]   stg_nxt [1:NPFX];

  pg_t  [WIDTH:0]   lvl_in  [0:LOG2W-1];
  pg_t  [WIDTH:0]   lvl_out [0:LOG2W-1];

  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

`ifdef KS_ADDER_SUB_EN
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;
`else
  assign b_eff   = in_b;
  assign cin_eff = in_cin;
`endif

  always_comb begin
    pg0[0].p = 1'b0;
    pg0[0].g = cin_eff;
    for (int i = 0; i < WIDTH; i++) begin
      pg0[i+1].p = in_a[i] ^ b_eff[i];
      pg0[i+1].g = in_a[i] & b_eff[i];
    end
  end

  // A level reads a register when it opens a stage, otherwise chains off the previous level.
  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    if (k % LVL_PER_STG == 0) begin : g_from_reg
      assign lvl_in[k] = stg_pg[k / LVL_PER_STG];
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end
    ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
      .pg_in  (lvl_in[k]),
      .pg_out (lvl_out[k])
    );
  end

  for (genvar s = 1; s <= NPFX; s++) begin : g_stg
    localparam int LAST = (s * LVL_PER_STG < LOG2W) ? s * LVL_PER_STG - 1 : LOG2W - 1;
    assign stg_nxt[s] = lvl_out[LAST];
  end

  // Carry into bit i is the group generate at position i. The top position misses bit -1
  // only when WIDTH is a power of two, so one extra gray combine closes it.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      sum_nxt[i] = stg_p[NPFX][i] ^ stg_pg[NPFX][i].g;
    end
    cout_nxt = stg_pg[NPFX][WIDTH].g | (stg_pg[NPFX][WIDTH].p & stg_pg[NPFX][0].g);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= NPFX; s++) begin
        stg_vld[s] <= 1'b0;
        stg_pg[s]  <= '0;
        stg_p[s]   <= '0;
        stg_tag[s] <= '0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_tag   <= '0;
`ifdef KS_ADDER_SUB_EN
      out_ovf   <= 1'b0;
`endif
    end else if (adv) begin
      stg_vld[0] <= in_valid;
      if (in_valid) begin
        stg_pg[0]  <= pg0;
        stg_p[0]   <= in_a ^ b_eff;
        stg_tag[0] <= in_tag;
      end
      for (int s = 1; s <= NPFX; s++) begin
        stg_vld[s] <= stg_vld[s-1];
        if (stg_vld[s-1]) begin
          stg_pg[s]  <= stg_nxt[s];
          stg_p[s]   <= stg_p[s-1];
          stg_tag[s] <= stg_tag[s-1];
        end
      end
      out_valid <= stg_vld[NPFX];
      if (stg_vld[NPFX]) begin
        out_sum  <= sum_nxt;
        out_cout <= cout_nxt;
        out_tag  <= stg_tag[NPFX];
`ifdef KS_ADDER_SUB_EN
        out_ovf  <= stg_pg[NPFX][WIDTH-1].g ^ cout_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: random ops against an arithmetic scoreboard, plus latency, stall, reset
// and 13-bit/LPS=2 corner cases; subtract checks when KS_ADDER_SUB_EN is defined.
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [15:0] in_a, in_b, out_sum;
  logic [3:0]  in_tag, out_tag;
  logic        sub_cur;

  logic        w_in_valid, w_in_ready, w_cin, w_out_valid, w_cout;
  logic [12:0] w_a, w_b, w_sum;
  logic [3:0]  w_tag_in, w_tag_out;

`ifdef KS_ADDER_SUB_EN
  logic in_sub, out_ovf, w_sub, w_ovf;
  assign sub_cur = in_sub;
`else
  assign sub_cur = 1'b0;
`endif

  ks_adder_pipe #(.WIDTH(16), .LVL_PER_STG(1), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
`ifdef KS_ADDER_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
`ifdef KS_ADDER_SUB_EN
    .out_ovf(out_ovf),
`endif
    .out_tag(out_tag)
  );

  ks_adder_pipe #(.WIDTH(13), .LVL_PER_STG(2), .TAG_W(4)) dut13 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_a), .in_b(w_b), .in_cin(w_cin), .in_tag(w_tag_in),
`ifdef KS_ADDER_SUB_EN
    .in_sub(w_sub),
`endif
    .out_valid(w_out_valid), .out_ready(1'b1), .out_sum(w_sum), .out_cout(w_cout),
`ifdef KS_ADDER_SUB_EN
    .out_ovf(w_ovf),
`endif
    .out_tag(w_tag_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  // Reference: plain integer arithmetic; overflow is the signed result leaving the 16-bit range.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic sub, input logic [3:0] tag);
    exp_t e;
    int   uns, sgn;
    if (sub) begin
      uns = int'(a) + 65536 - int'(b);
      sgn = int'($signed(a)) - int'($signed(b));
    end else begin
      uns = int'(a) + int'(b) + int'(cin);
      sgn = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    e.sum  = 16'(uns % 65536);
    e.cout = (uns >= 65536);
    e.ovf  = (sgn > 32767) || (sgn < -32768);
    e.tag  = tag;
    return e;
  endfunction

  exp_t q[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          sb_e = q.pop_front();
          chk("sb_sum", {16'd0, out_sum}, {16'd0, sb_e.sum});
          chk("sb_cout", {31'd0, out_cout}, {31'd0, sb_e.cout});
          chk("sb_tag", {28'd0, out_tag}, {28'd0, sb_e.tag});
`ifdef KS_ADDER_SUB_EN
          chk("sb_ovf", {31'd0, out_ovf}, {31'd0, sb_e.ovf});
`endif
        end
        n_out++;
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, sub_cur, in_tag));
    end
  end

  task automatic rand_op();
    in_a   = 16'($urandom);
    in_b   = 16'($urandom);
    in_cin = 1'($urandom);
    in_tag = 4'($urandom);
`ifdef KS_ADDER_SUB_EN
    in_sub = 1'($urandom);
`endif
  endtask

  // Entered and left at posedge+1; returns cycles from accept to out_valid (-1 on timeout).
  task automatic send_measure(input logic [15:0] a, input logic [15:0] b, input logic c,
                              input logic [3:0] t, output int lat);
    in_a = a; in_b = b; in_cin = c; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic op13(input logic [12:0] a, input logic [12:0] b, input logic c, input logic [3:0] t);
    int          lat;
    logic [13:0] full;
    full = {1'b0, a} + {1'b0, b} + {13'd0, c};
    w_a = a; w_b = b; w_cin = c; w_tag_in = t; w_in_valid = 1'b1;
    @(negedge clk);
    chk("w13_in_ready", {31'd0, w_in_ready}, 32'd1);
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (w_out_valid) begin
        lat = n;
        break;
      end
    end
    chk("w13_lat", lat, 32'd4);
    chk("w13_sum", {19'd0, w_sum}, {19'd0, full[12:0]});
    chk("w13_cout", {31'd0, w_cout}, {31'd0, full[13]});
    chk("w13_tag", {28'd0, w_tag_out}, {28'd0, t});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int n0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_tag = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_tag_in = '0;
`ifdef KS_ADDER_SUB_EN
    in_sub = 1'b0; w_sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_w13_valid", {31'd0, w_out_valid}, 32'd0);
    rst = 1'b0;

    // Carry ripples through every bit; LAT=6 at defaults.
    send_measure(16'hFFFF, 16'h0001, 1'b0, 4'h5, lat);
    chk("t1_lat", lat, 32'd6);
    chk("t1_sum", {16'd0, out_sum}, 32'h0);
    chk("t1_cout", {31'd0, out_cout}, 32'd1);
    chk("t1_tag", {28'd0, out_tag}, 32'h5);
    @(posedge clk); #1;

    // Back-to-back: 100 accepts must yield 100 results exactly LAT after the last accept.
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      rand_op();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("t2_throughput", n_out - n0, 32'd100);
    chk("t2_sb_empty", q.size(), 32'd0);
    @(posedge clk); #1;

    // Stall with a full pipeline.
    for (int i = 0; i < 8; i++) begin
      rand_op();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_sum", {16'd0, out_sum}, {16'd0, q[0].sum});
      chk("t3_hold_tag", {28'd0, out_tag}, {28'd0, q[0].tag});
      @(posedge clk); #1;
      rand_op();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_op();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("t3_sb_empty", q.size(), 32'd0);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      rand_op();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_rst_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4_no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
`ifdef KS_ADDER_SUB_EN
    in_sub = 1'b0;
`endif
    send_measure(16'h1234, 16'h0F0F, 1'b1, 4'hA, lat);
    chk("t4_lat", lat, 32'd6);
    chk("t4_sum", {16'd0, out_sum}, 32'h2144);
    @(posedge clk); #1;

`ifdef KS_ADDER_SUB_EN
    in_sub = 1'b1;
    send_measure(16'h8000, 16'h0001, 1'b0, 4'h3, lat);
    chk("t6_lat", lat, 32'd6);
    chk("t6_sum", {16'd0, out_sum}, 32'h7FFF);
    chk("t6_cout", {31'd0, out_cout}, 32'd1);
    chk("t6_ovf", {31'd0, out_ovf}, 32'd1);
    @(posedge clk); #1;
    in_sub = 1'b0;
`endif

    // 13-bit, two levels per stage: LAT=4.
    op13(13'h1FFF, 13'h0000, 1'b1, 4'h9);
    for (int i = 0; i < 10; i++) begin
      op13(13'($urandom), 13'($urandom), 1'($urandom), 4'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
